// File: rtl/divider16bits_restoring_pkg.sv
// Shared constants and state encoding for the 16/8 restoring divider.
//   DIVIDEND_W / DIVISOR_W : operand widths
//   ITER_COUNT             : restoring steps per division (one per dividend bit)
//   CNT_W                  : iteration counter width
//   PREM_W                 : partial remainder width (one guard bit above the divisor)
package divider16bits_restoring_pkg;

  localparam int unsigned DIVIDEND_W = 16;
  localparam int unsigned DIVISOR_W  = 8;
  localparam int unsigned ITER_COUNT = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned PREM_W     = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step.
//   prem_in  : current 9-bit partial remainder
//   dvd_bit  : next dividend bit, MSB first
//   divisor  : unsigned divisor
//   prem_out : partial remainder after the trial subtraction (restored if negative)
//   q_bit    : quotient bit produced by this step
module divider_step
  import divider16bits_restoring_pkg::*;
(
  input  logic [PREM_W-1:0]    prem_in,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [PREM_W-1:0]    prem_out,
  output logic                 q_bit
);

  logic [PREM_W-1:0] shifted;
  logic [PREM_W-1:0] dvs_ext;
  // The incoming remainder is always < divisor, so its top bit is never set.
  logic              unused_prem_msb;

  assign unused_prem_msb = prem_in[PREM_W-1];

  always_comb begin
    shifted  = {prem_in[DIVISOR_W-1:0], dvd_bit};
    dvs_ext  = {1'b0, divisor};
    q_bit    = (shifted >= dvs_ext);
    prem_out = q_bit ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/divider16bits_restoring.sv
// Sequential 16-bit by 8-bit unsigned restoring divider, one quotient bit per clock.
//   CLK       : clock, rising edge
//   RESET     : synchronous active-high reset
//   S         : start request (level); a new start needs S low for one edge in DONE
//   dividend  : 16-bit numerator, captured on the start edge
//   divisor   : 8-bit denominator, captured on the start edge
//   quotient  : registered quotient, held in IDLE
//   remainder : registered remainder, held in IDLE
//   PRONTO    : result valid (DONE)
//   DIVZERO   : result came from a zero divisor
module divider16bits_restoring
  import divider16bits_restoring_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  S,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  PRONTO,
  output logic                  DIVZERO
);

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITER_COUNT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PREM_W-1:0]     prem_q, prem_d;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVIDEND_W-1:0] quot_q, quot_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  pronto_q, pronto_d;
  logic                  divzero_q, divzero_d;

  logic [PREM_W-1:0]     prem_next;
  logic                  q_bit;

  divider_step u_step (
    .prem_in  (prem_q),
    .dvd_bit  (shreg_q[DIVIDEND_W-1]),
    .divisor  (dvs_q),
    .prem_out (prem_next),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prem_d    = prem_q;
    shreg_d   = shreg_q;
    dvs_d     = dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    pronto_d  = pronto_q;
    divzero_d = divzero_q;

    unique case (state_q)
      IDLE: begin
        if (S) begin
          if (divisor == '0) begin
            state_d   = DONE;
            quot_d    = '1;
            rem_d     = '0;
            pronto_d  = 1'b1;
            divzero_d = 1'b1;
          end else begin
            state_d = CALC;
            shreg_d = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = '0;
          end
        end
      end

      CALC: begin
        prem_d  = prem_next;
        shreg_d = {shreg_q[DIVIDEND_W-2:0], q_bit};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LastIter) begin
          state_d   = DONE;
          quot_d    = {shreg_q[DIVIDEND_W-2:0], q_bit};
          rem_d     = prem_next[DIVISOR_W-1:0];
          pronto_d  = 1'b1;
          divzero_d = 1'b0;
        end
      end

      DONE: begin
        // Holding S high keeps the result; only a low S returns to IDLE.
        if (!S) begin
          state_d   = IDLE;
          pronto_d  = 1'b0;
          divzero_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      prem_q    <= '0;
      shreg_q   <= '0;
      dvs_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      pronto_q  <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prem_q    <= prem_d;
      shreg_q   <= shreg_d;
      dvs_q     <= dvs_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      pronto_q  <= pronto_d;
      divzero_q <= divzero_d;
    end
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign PRONTO    = pronto_q;
  assign DIVZERO   = divzero_q;

endmodule

// File: doc/divider16bits_restoring.md
DIVIDER16BITS_RESTORING -- requirements
Module: divider16bits_restoring

Interface
REQ-001 The module SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port RESET, input, 1, a synchronous, active-high reset sampled on the CLK rising edge.
REQ-003 The module SHALL have port S, input, 1, the start request, level-sensitive, sampled only in IDLE and DONE.
REQ-004 The module SHALL have port dividend, input, 16, an unsigned numerator, sampled on the start edge only.
REQ-005 The module SHALL have port divisor, input, 8, an unsigned denominator, sampled on the start edge only.
REQ-006 The module SHALL have port quotient, output, 16, the unsigned quotient, registered.
REQ-007 The module SHALL have port remainder, output, 8, the unsigned remainder, registered.
REQ-008 The module SHALL have port PRONTO, output, 1, which is high while a result is valid (state DONE), registered.
REQ-009 The module SHALL have port DIVZERO, output, 1, which is high with PRONTO when the captured divisor was 0, registered.

Function
REQ-010 The block SHALL implement the states IDLE, CALC and DONE.
REQ-011 In IDLE with S=1 and divisor!=0, the next edge SHALL capture the operands, clear the 9-bit partial remainder, load a 5-bit iteration counter with 0, and go to CALC.
REQ-012 In IDLE with S=1 and divisor=0, the next edge SHALL go directly to DONE with quotient=16'hFFFF, remainder=8'h00 and DIVZERO=1.
REQ-013 Each CALC cycle SHALL perform one restoring step, MSB first.
REQ-014 In each step, the partial remainder SHALL become {partial remainder[7:0], next dividend bit}.
REQ-015 In each step, if that value is >= divisor, it SHALL be reduced by divisor and the quotient bit SHALL be 1; otherwise the quotient bit SHALL be 0.
REQ-016 Exactly 16 CALC cycles SHALL occur.
REQ-017 On the 16th CALC edge the block SHALL load quotient and remainder, set PRONTO=1 and DIVZERO=0, and enter DONE.
REQ-018 Latency SHALL be 17 CLK edges from the start edge to PRONTO=1 for nonzero divisors, and 1 edge for divide-by-zero.
REQ-019 In CALC, S and operand inputs SHALL be ignored.
REQ-020 Operand changes after the start edge SHALL NOT affect the result.
REQ-021 In DONE, PRONTO, quotient, remainder and DIVZERO SHALL hold stable while S=1.
REQ-022 The edge on which DONE sees S=0 SHALL go to IDLE and clear PRONTO and DIVZERO.
REQ-023 quotient and remainder SHALL hold their last values in IDLE.
REQ-024 A new start SHALL require S to be low for at least one edge in DONE, so that S held high gives exactly one division.
REQ-025 Results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, for every divisor != 0.
REQ-026 The internal partial remainder SHALL be 9 bits wide so that no step overflows.

Reset
REQ-027 RESET=1 on a rising edge SHALL force IDLE and set quotient=0, remainder=0, PRONTO=0, DIVZERO=0 and the counter to 0, from any state including mid-CALC.
REQ-028 RESET SHALL take priority over S.
REQ-029 A division in progress when RESET is applied SHALL be abandoned with no PRONTO pulse.
REQ-030 After RESET deasserts, with S=1 in IDLE, a new division SHALL start on the next edge.

Structure
REQ-031 A shared package SHALL hold the state encoding constants (IDLE, CALC, DONE), the width constants DIVIDEND_W=16 and DIVISOR_W=8, and ITER_COUNT=16.
REQ-032 One combinational sub-module, divider_step, SHALL take the 9-bit partial remainder, the incoming dividend bit and the divisor, and SHALL output the next partial remainder and the quotient bit.
REQ-033 The top level SHALL contain the FSM, the counter, and the shift and output registers.

Verification
REQ-034 Directed test: RESET for 1 cycle, then S=1, dividend=391, divisor=23 -> after 17 edges PRONTO=1, quotient=17, remainder=0, DIVZERO=0; with S held high the values hold and there is no restart.
REQ-035 Directed test: dividend=1000, divisor=7 -> quotient=142, remainder=6; dividend=5, divisor=9 -> quotient=0, remainder=5.
REQ-036 Directed test: dividend=65535, divisor=1 -> quotient=65535, remainder=0; dividend=65535, divisor=255 -> quotient=257, remainder=0.
REQ-037 Directed test: dividend=100, divisor=0 -> one edge later PRONTO=1, DIVZERO=1, quotient=16'hFFFF, remainder=0.
REQ-038 Directed test: RESET asserted at CALC cycle 8 -> next edge IDLE with all outputs 0 and no PRONTO; a subsequent 391/23 gives 17 r0.
REQ-039 Directed test: change dividend and divisor mid-CALC -> the result matches the operands captured on the start edge; drop S in DONE -> PRONTO falls on the next edge.
